// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 AEAD controller.
// Round indices are 4-bit because the datapath round input is 0..11.
package ascon_pack;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_WAIT_AD = 3'd2,
      ST_AD      = 3'd3,
      ST_WAIT_PT = 3'd4,
      ST_PT      = 3'd5,
      ST_FINAL   = 3'd6,
      ST_DONE    = 3'd7
   } state_fsm_t;

   localparam int         ROUNDS_A       = 12;
   localparam logic [3:0] ROUNDS_B_START = 4'd6;
   localparam logic [3:0] LAST_ROUND     = 4'(ROUNDS_A - 1);

   // Rounds at which the per-block side effects happen.
   localparam logic [3:0] ROUND_A_FIRST  = 4'd0;
   localparam logic [3:0] ROUND_A_CIPHER = 4'd1;
   localparam logic [3:0] ROUND_B_CIPHER = 4'd7;

endpackage

// File: rtl/ascon_round_counter.sv
// Permutation round counter: loads 0 (p12) or 6 (p6) and counts up,
// saturating at the last round so WAIT states see a stable value.
module ascon_round_counter
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       init_a_i,
   input  logic       init_b_i,
   input  logic       en_i,
   output logic [3:0] round_o,
   output logic       last_o
);

   logic [3:0] round_q;
   logic [3:0] round_d;

   always_comb begin
      round_d = round_q;
      if (init_a_i) begin
         round_d = ROUND_A_FIRST;
      end else if (init_b_i) begin
         round_d = ROUNDS_B_START;
      end else if (en_i && (round_q != LAST_ROUND)) begin
         round_d = round_q + 4'd1;
      end
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         round_q <= 4'd0;
      end else begin
         round_q <= round_d;
      end
   end

   assign round_o = round_q;
   assign last_o  = (round_q == LAST_ROUND);

endmodule

// File: rtl/ascon_fsm.sv
// Moore controller sequencing the permutation_xor datapath through one
// ASCON-128 encryption: p12 init, one AD block, NB_BLOCKS PT blocks, p12 final.
module ascon_fsm
   import ascon_pack::*;
#(
   parameter int NB_BLOCKS = 4
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       data_valid_i,
   output logic       ready_o,
   output logic       sel_o,
   output logic       en_reg_state_o,
   output logic [3:0] round_o,
   output logic       en_xor_data_o,
   output logic       en_xor_key_begin_o,
   output logic       en_xor_lsb_o,
   output logic       en_xor_key_end_o,
   output logic       en_cypher_begin_o,
   output logic       en_tag_end_o,
   output logic       cipher_valid_o,
   output logic       done_o,
   output state_fsm_t state_o
);

   localparam int            BW       = $clog2(NB_BLOCKS) + 1;
   localparam logic [BW-1:0] LAST_BLK = BW'(NB_BLOCKS - 1);

   state_fsm_t    state_q, state_d;
   logic [BW-1:0] blk_q, blk_d;
   logic          init_a, init_b, cnt_en;
   logic [3:0]    round;
   logic          last;

   ascon_round_counter u_round_counter (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .init_a_i (init_a),
      .init_b_i (init_b),
      .en_i     (cnt_en),
      .round_o  (round),
      .last_o   (last)
   );

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= ST_IDLE;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
      end
   end

   // Handshake: data_valid_i is only looked at while ready_o=1 (WAIT states);
   // the block is consumed on that edge and the permutation starts next cycle.
   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      init_a  = 1'b0;
      init_b  = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d = ST_INIT;
               init_a  = 1'b1;
            end
         end
         ST_INIT: begin
            cnt_en = 1'b1;
            if (last) state_d = ST_WAIT_AD;
         end
         ST_WAIT_AD: begin
            if (data_valid_i) begin
               state_d = ST_AD;
               init_b  = 1'b1;
            end
         end
         ST_AD: begin
            cnt_en = 1'b1;
            if (last) begin
               state_d = ST_WAIT_PT;
               blk_d   = '0;
            end
         end
         ST_WAIT_PT: begin
            if (data_valid_i) begin
               if (blk_q == LAST_BLK) begin
                  state_d = ST_FINAL;
                  init_a  = 1'b1;
               end else begin
                  state_d = ST_PT;
                  init_b  = 1'b1;
               end
            end
         end
         ST_PT: begin
            cnt_en = 1'b1;
            if (last) begin
               state_d = ST_WAIT_PT;
               blk_d   = blk_q + BW'(1);
            end
         end
         ST_FINAL: begin
            cnt_en = 1'b1;
            if (last) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready_o            = 1'b0;
      sel_o              = 1'b0;
      en_reg_state_o     = 1'b0;
      en_xor_data_o      = 1'b0;
      en_xor_key_begin_o = 1'b0;
      en_xor_lsb_o       = 1'b0;
      en_xor_key_end_o   = 1'b0;
      en_cypher_begin_o  = 1'b0;
      en_tag_end_o       = 1'b0;
      cipher_valid_o     = 1'b0;
      done_o             = 1'b0;
      case (state_q)
         ST_INIT: begin
            en_reg_state_o   = 1'b1;
            sel_o            = (round != ROUND_A_FIRST);
            en_xor_key_end_o = last;
         end
         ST_WAIT_AD, ST_WAIT_PT: begin
            ready_o = 1'b1;
            sel_o   = 1'b1;
         end
         ST_AD: begin
            sel_o          = 1'b1;
            en_reg_state_o = 1'b1;
            en_xor_data_o  = (round == ROUNDS_B_START);
            en_xor_lsb_o   = last;
         end
         ST_PT: begin
            sel_o             = 1'b1;
            en_reg_state_o    = 1'b1;
            en_xor_data_o     = (round == ROUNDS_B_START);
            en_cypher_begin_o = (round == ROUNDS_B_START);
            cipher_valid_o    = (round == ROUND_B_CIPHER);
         end
         ST_FINAL: begin
            sel_o              = 1'b1;
            en_reg_state_o     = 1'b1;
            en_xor_data_o      = (round == ROUND_A_FIRST);
            en_cypher_begin_o  = (round == ROUND_A_FIRST);
            en_xor_key_begin_o = (round == ROUND_A_FIRST);
            cipher_valid_o     = (round == ROUND_A_CIPHER);
            en_xor_key_end_o   = last;
            en_tag_end_o       = last;
         end
         ST_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   assign round_o = round;
   assign state_o = state_q;

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: per-cycle input/expected-output queues built from the
// encryption schedule, checked for NB_BLOCKS=4 and NB_BLOCKS=1 instances.
module tb_ascon_fsm;
   import ascon_pack::*;

   localparam int W = 15;

   logic clk, rst_n, start, dv;
   int   checks, failures;

   logic [1:0]   in_q[$];
   logic [W-1:0] exp_q[$];

   logic       rdy4, sel4, en4, xd4, kb4, lsb4, ke4, cb4, te4, cv4, dn4;
   logic [3:0] rnd4;
   state_fsm_t state4;
   logic       rdy1, sel1, en1, xd1, kb1, lsb1, ke1, cb1, te1, cv1, dn1;
   logic [3:0] rnd1;
   state_fsm_t state1;
   logic [W-1:0] obs4, obs1;

   assign obs4 = {rdy4, sel4, en4, rnd4, xd4, kb4, lsb4, ke4, cb4, te4, cv4, dn4};
   assign obs1 = {rdy1, sel1, en1, rnd1, xd1, kb1, lsb1, ke1, cb1, te1, cv1, dn1};

   ascon_fsm #(.NB_BLOCKS(4)) dut4 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start), .data_valid_i(dv),
      .ready_o(rdy4), .sel_o(sel4), .en_reg_state_o(en4), .round_o(rnd4),
      .en_xor_data_o(xd4), .en_xor_key_begin_o(kb4), .en_xor_lsb_o(lsb4),
      .en_xor_key_end_o(ke4), .en_cypher_begin_o(cb4), .en_tag_end_o(te4),
      .cipher_valid_o(cv4), .done_o(dn4), .state_o(state4)
   );

   ascon_fsm #(.NB_BLOCKS(1)) dut1 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start), .data_valid_i(dv),
      .ready_o(rdy1), .sel_o(sel1), .en_reg_state_o(en1), .round_o(rnd1),
      .en_xor_data_o(xd1), .en_xor_key_begin_o(kb1), .en_xor_lsb_o(lsb1),
      .en_xor_key_end_o(ke1), .en_cypher_begin_o(cb1), .en_tag_end_o(te1),
      .cipher_valid_o(cv1), .done_o(dn1), .state_o(state1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] vec(input logic rdy, input logic sel, input logic en,
                                        input int rnd, input logic xd, input logic kb,
                                        input logic lsb, input logic ke, input logic cb,
                                        input logic te, input logic cv, input logic dn);
      return {rdy, sel, en, 4'(rnd), xd, kb, lsb, ke, cb, te, cv, dn};
   endfunction

   task automatic push_cyc(input logic st, input logic d, input logic [W-1:0] e);
      in_q.push_back({st, d});
      exp_q.push_back(e);
   endtask

   task automatic push_init(input logic noise);
      for (int r = 0; r < 12; r++)
         push_cyc(noise && r == 5, noise && r == 3,
                  vec(0, r != 0, 1, r, 0, 0, 0, r == 11, 0, 0, 0, 0));
   endtask

   // stall idle cycles before the accepting cycle; start_i is ignored here
   task automatic push_wait(input int stall);
      for (int i = 0; i <= stall; i++)
         push_cyc(stall > 0 && i == 0, i == stall, vec(1, 1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic push_ad();
      for (int r = 6; r < 12; r++)
         push_cyc(0, 0, vec(0, 1, 1, r, r == 6, 0, r == 11, 0, 0, 0, 0, 0));
   endtask

   task automatic push_pt(input logic noise);
      for (int r = 6; r < 12; r++)
         push_cyc(0, noise && r == 8, vec(0, 1, 1, r, r == 6, 0, 0, 0, r == 6, 0, r == 7, 0));
   endtask

   task automatic push_final(input int n, input logic noise);
      for (int r = 0; r < n; r++)
         push_cyc(noise && r == 4, 0,
                  vec(0, 1, 1, r, r == 0, r == 0, 0, r == 11, r == 0, r == 11, r == 1, 0));
   endtask

   task automatic push_done(input int n, input logic st, input logic d);
      for (int i = 0; i < n; i++)
         push_cyc(st && i == n - 1, d && i == n - 1, vec(0, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 1));
   endtask

   task automatic push_message(input int nb, input int stall, input logic noise);
      push_init(noise);
      push_wait(stall);
      push_ad();
      for (int b = 0; b < nb - 1; b++) begin
         push_wait(stall);
         push_pt(noise);
      end
      push_wait(stall);
      push_final(12, noise);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; dv = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs4 !== '0) begin
         failures++; $display("FAIL reset_outputs4 got=%h exp=%h", obs4, {W{1'b0}});
      end
      checks++;
      if (obs1 !== '0) begin
         failures++; $display("FAIL reset_outputs1 got=%h exp=%h", obs1, {W{1'b0}});
      end
      checks++;
      if (state4 !== ST_IDLE) begin
         failures++; $display("FAIL reset_state got=%0d exp=%0d", state4, ST_IDLE);
      end
      start = 1'b0; dv = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs4 !== '0) begin
         failures++; $display("FAIL idle_no_start got=%h exp=%h", obs4, {W{1'b0}});
      end
   endtask

   task automatic test_full_no_stall();
      int idx, cv_cnt, done_idx;
      logic [W-1:0] e;
      idx = 0; cv_cnt = 0; done_idx = -1;
      push_cyc(1, 0, '0);
      push_message(4, 0, 0);
      push_done(2, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {start, dv} = in_q.pop_front();
         checks++;
         if (obs4 !== e) begin
            failures++; $display("FAIL full cyc=%0d got=%h exp=%h", idx, obs4, e);
         end
         if (obs4[1] === 1'b1) cv_cnt++;
         if (obs4[0] === 1'b1 && done_idx < 0) done_idx = idx;
         idx++;
         @(posedge clk); #1;
      end
      start = 1'b0; dv = 1'b0;
      checks++;
      if (cv_cnt != 4) begin
         failures++; $display("FAIL cipher_pulses got=%0d exp=4", cv_cnt);
      end
      // start sampled at the end of cycle 0; done must follow 53 edges later
      checks++;
      if (done_idx != 54) begin
         failures++; $display("FAIL done_latency got=%0d exp=54", done_idx);
      end
      checks++;
      if (state4 !== ST_DONE) begin
         failures++; $display("FAIL done_state got=%0d exp=%0d", state4, ST_DONE);
      end
   endtask

   task automatic test_restart_with_stalls();
      int idx;
      logic [W-1:0] e;
      idx = 0;
      push_done(1, 1, 1);
      push_message(4, 5, 1);
      push_done(2, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {start, dv} = in_q.pop_front();
         checks++;
         if (obs4 !== e) begin
            failures++; $display("FAIL restart_stall cyc=%0d got=%h exp=%h", idx, obs4, e);
         end
         idx++;
         @(posedge clk); #1;
      end
      start = 1'b0; dv = 1'b0;
   endtask

   task automatic test_reset_mid_final();
      int idx;
      logic [W-1:0] e;
      idx = 0;
      push_done(1, 1, 0);
      push_init(0);
      push_wait(0);
      push_ad();
      for (int b = 0; b < 3; b++) begin
         push_wait(0);
         push_pt(0);
      end
      push_wait(0);
      push_final(5, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {start, dv} = in_q.pop_front();
         checks++;
         if (obs4 !== e) begin
            failures++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", idx, obs4, e);
         end
         idx++;
         @(posedge clk); #1;
      end
      start = 1'b0; dv = 1'b0;
      checks++;
      if (rnd4 !== 4'd5 || en4 !== 1'b1) begin
         failures++; $display("FAIL final_round5 got=%0d/%b exp=5/1", rnd4, en4);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs4 !== '0 || state4 !== ST_IDLE) begin
         failures++; $display("FAIL async_reset got=%h/%0d exp=0/%0d", obs4, state4, ST_IDLE);
      end
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs4 !== '0) begin
         failures++; $display("FAIL reset_hold got=%h exp=%h", obs4, {W{1'b0}});
      end
      start = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      idx = 0;
      push_cyc(1, 0, '0);
      push_message(4, 0, 0);
      push_done(1, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {start, dv} = in_q.pop_front();
         checks++;
         if (obs4 !== e) begin
            failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", idx, obs4, e);
         end
         idx++;
         @(posedge clk); #1;
      end
      start = 1'b0; dv = 1'b0;
   endtask

   task automatic test_nb1();
      int idx;
      logic [W-1:0] e;
      idx = 0;
      rst_n = 1'b0;
      @(posedge clk);
      #4 rst_n = 1'b1;
      @(posedge clk); #1;
      push_cyc(1, 0, '0);
      push_message(1, 0, 0);
      push_done(2, 1, 0);
      push_init(0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {start, dv} = in_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            failures++; $display("FAIL nb1 cyc=%0d got=%h exp=%h", idx, obs1, e);
         end
         idx++;
         @(posedge clk); #1;
      end
      start = 1'b0; dv = 1'b0;
      checks++;
      if (state1 !== ST_WAIT_AD) begin
         failures++; $display("FAIL nb1_state got=%0d exp=%0d", state1, ST_WAIT_AD);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; start = 1'b0; dv = 1'b0;
      test_reset();
      test_full_no_stall();
      test_restart_with_stalls();
      test_reset_mid_final();
      test_nb1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
